// File: rtl/pipe_ctrl_seq.sv
// pipe_ctrl_seq: central pipeline controller for the 5-stage core.
// Merges per-stage stall requests into the 6-bit stall vector, sequences
// exception / ERET redirection (IDLE -> FLUSH -> SETTLE) with a registered
// one-cycle flush pulse and redirect address, and masks new exceptions for
// SETTLE_CYCLES cycles after each redirect.
// Optional feature macro: STALL_WATCHDOG_EN adds a sticky stall watchdog
// (wdt_timeout) tripping after WDT_LIMIT consecutive stalled-PC cycles;
// without it wdt_timeout is constant 0 and no counter exists.
module pipe_ctrl_seq #(
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
    parameter int          SETTLE_CYCLES = 3
`ifdef STALL_WATCHDOG_EN
    ,
    parameter int          WDT_LIMIT     = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        ctrl_busy,
    output logic        wdt_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [31:0] ERET_CODE   = 32'h0000000e;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] settle_cnt;

    // Stall vector: deepest requesting stage wins; silenced in reset and during flush.
    always_comb begin
        stall = 6'b000000;
        if (rst && !flush) begin
            if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id || stallreq_if) begin
                stall = 6'b000111;
            end
        end
    end

    // Redirect FSM: accept exception, pulse flush for one cycle, then hold off new exceptions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            flush      <= 1'b0;
            new_pc     <= 32'h0;
            settle_cnt <= 4'd0;
            ctrl_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((excepttype_i != 32'h0) && !stallreq_mem) begin
                        state     <= FLUSH;
                        flush     <= 1'b1;
                        ctrl_busy <= 1'b1;
                        if (excepttype_i == ERET_CODE) begin
                            new_pc <= cp0_epc_i;
                        end else begin
                            new_pc <= EXC_VECTOR;
                        end
                    end
                end
                FLUSH: begin
                    state      <= SETTLE;
                    flush      <= 1'b0;
                    settle_cnt <= SETTLE_LOAD;
                    ctrl_busy  <= 1'b1;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        state      <= IDLE;
                        settle_cnt <= 4'd0;
                        ctrl_busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    flush      <= 1'b0;
                    settle_cnt <= 4'd0;
                    ctrl_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_WATCHDOG_EN
    localparam logic [15:0] WDT_MAX = 16'(WDT_LIMIT);

    logic [15:0] wdt_cnt;

    // Watchdog: count consecutive stalled-PC edges, trip a sticky flag at the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_cnt     <= 16'd0;
            wdt_timeout <= 1'b0;
        end else if (!stall[0] || flush) begin
            wdt_cnt <= 16'd0;
        end else if (wdt_cnt != WDT_MAX) begin
            wdt_cnt <= wdt_cnt + 16'd1;
            if ((wdt_cnt + 16'd1) == WDT_MAX) begin
                wdt_timeout <= 1'b1;
            end
        end
    end
`else
    assign wdt_timeout = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and the stage latches. It sequences exception and ERET redirection through a small FSM that produces a registered one-cycle flush pulse and the redirect address for the PC register. After each redirect it enforces a settle window.

Parameters:
EXC_VECTOR, 32'h00000020, redirect target for all non-ERET exceptions
SETTLE_CYCLES, 3, cycles after a flush during which new exceptions are masked (range 1..15)
WDT_LIMIT, 1024, consecutive stalled-PC cycles before watchdog trip (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 at a clk edge resets the block)
stallreq_if  input  1  fetch-stage stall request
stallreq_id  input  1  decode-stage stall request
stallreq_ex  input  1  execute-stage stall request
stallreq_mem  input  1  memory-stage stall request
excepttype_i  input  32  exception code from the mem stage; 0 = none
cp0_epc_i  input  32  current CP0 EPC
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  output  1  one-cycle registered flush pulse
new_pc  output  32  redirect address, valid while flush==1
ctrl_busy  output  1  1 while the FSM is not in IDLE
wdt_timeout  output  1  sticky stall-watchdog flag

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, flush=0, new_pc=0, settle counter=0, wdt counter=0, wdt_timeout=0, ctrl_busy=0. stall is combinational and evaluates to 0 while rst==0. Reset mid-flush or mid-settle aborts the sequence at that edge.
- Stall vector, combinational, highest stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000111
  - none: 6'b000000
- Whenever flush==1, stall is forced to 0.
- FSM states: IDLE, FLUSH, SETTLE.
- IDLE:
  - An exception is accepted when excepttype_i!=0 and stallreq_mem==0 at an edge.
  - An exception arriving while stallreq_mem==1 is not latched. The mem stage holds it, so it is accepted on the first edge with stallreq_mem==0.
  - On acceptance: go to FLUSH; register flush<=1.
  - new_pc <= cp0_epc_i if excepttype_i==32'h0000000e (ERET); otherwise new_pc <= EXC_VECTOR. The EPC is sampled at the acceptance edge.
- FLUSH: lasts exactly one cycle (flush==1 throughout). At the next edge: flush<=0, load settle counter with SETTLE_CYCLES, go to SETTLE. excepttype_i is ignored.
- SETTLE:
  - Counter decrements each edge; excepttype_i is ignored.
  - When the counter reaches 0, go to IDLE at that edge.
  - Stall requests still pass through normally.
- Latency: exception accepted at edge N; flush high during cycle N+1; the PC loads new_pc at edge N+2. The first exception re-accept is possible at edge N+2+SETTLE_CYCLES.
- ctrl_busy = (state!=IDLE), registered with the state.
- new_pc holds its last value after flush drops.

Optional Feature:
STALL_WATCHDOG_EN:
- Defined:
  - A 16-bit counter increments on each edge where stall[0]==1 and clears on any edge where stall[0]==0 or flush==1.
  - When the counter reaches WDT_LIMIT, wdt_timeout<=1. It stays sticky until reset, and the counter saturates.
- Undefined: no counter is synthesised; wdt_timeout is tied to 0.

Test Plan:
- Priority: stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111. Then add stallreq_mem=1 -> 6'b011111. Drop all requests -> 6'b000000 in the same cycle.
- Syscall: excepttype_i=32'h8 for one cycle in IDLE, stallreq_ex=1 -> next cycle flush=1, new_pc=32'h00000020, stall=0, ctrl_busy=1. flush=0 one cycle later.
- ERET: cp0_epc_i=32'h0000_1234, excepttype_i=32'he -> flush pulse with new_pc=32'h00001234.
- Masking: second exception presented 1 cycle after flush (SETTLE_CYCLES=3) -> no flush. The same exception held until the settle window expires -> accepted; flush follows exactly 4 cycles after the first flush's end.
- Deferred: excepttype_i=32'hc with stallreq_mem=1 for 5 cycles -> no flush. stallreq_mem drops -> flush on the following cycle.
- Reset/watchdog: rst=0 during flush -> flush=0, ctrl_busy=0 next edge. With STALL_WATCHDOG_EN and WDT_LIMIT=8, stallreq_if held for 8 cycles -> wdt_timeout=1, and it remains 1 after the stall drops.
